axi_txn_monitor: RTL and testbench
==================================

Name: axi_txn_monitor

Overview:
- Passive, parametrised AXI3/AXI4 transaction monitor for the VIP assertion environment.
- Sits alongside the VIP interface binding on one master port; observes all five channels and never drives the bus.
- Tracks outstanding writes and reads by ID, checks VALID stability, LAST placement and ID matching, and reports sticky error flags and completion counters.
- Generalises the port wrapper with configurable ID, length and outstanding-depth widths.

Parameters:
- ID_SIZE, 4, width of AWID/ARID/BID/RID.
- LEN_W, 4, burst length field width: 4 for AXI3, 8 for AXI4.
- MAX_OUT, 8, outstanding transaction table depth per direction.
- CNT_W, 16, completion counter width.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of sticky errors and counters
- AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY, RLAST  in  1 each  observed handshake/last signals
- AWID, ARID, BID, RID  in  ID_SIZE  observed IDs
- AWLEN, ARLEN  in  LEN_W  burst length minus 1
- AWADDR, ARADDR  in  32  observed addresses (stability check only)
- BRESP, RRESP  in  2  observed responses
- wr_outstanding  out  $clog2(MAX_OUT+1)  writes accepted on AW and not yet completed on B
- rd_outstanding  out  $clog2(MAX_OUT+1)  reads accepted on AR and not yet completed by RLAST
- wr_done_cnt, rd_done_cnt  out  CNT_W  completed transactions, saturating
- resp_err_cnt  out  CNT_W  count of B/R handshakes with RESP != 2'b00, saturating
- err_sticky  out  10  sticky error vector
- err_pulse  out  1  high for one cycle when any error bit transitions 0 to 1

Behaviour:
- Handshake: a channel transfer occurs on a rising CLK edge with VALID && READY both high.
- Reset: all outputs are 0, both tables are empty, and the stability shadow registers are cleared.
- Reset mid-operation discards all tracked transactions. Subsequent B/R beats with no matching entry set their error bits.
- clr zeroes err_sticky, all counters and err_pulse. It does not touch the tables or the outstanding counts.
- Error outputs are registered. A violation sampled at edge N is visible after edge N.
- Write table (FIFO, MAX_OUT entries of {id, len, beat_cnt, wdone}):
  - An AW handshake pushes an entry.
  - Each W handshake increments beat_cnt of the oldest entry with wdone=0.
  - When a W beat is the last beat, wdone is set on that entry.
- W before AW is not supported. A W beat with no entry where wdone=0 sets bit4.
- Exception: an AW handshake and a W handshake in the same cycle with no open entry count as a bypass, with no error.
- A B handshake retires the oldest entry with wdone=1 and id==BID. If no such entry exists, bit5 is set.
- Read table (MAX_OUT entries of {id, len, beat_cnt}):
  - An AR handshake allocates an entry.
  - An R handshake updates the oldest entry with id==RID. If none exists, bit6 is set.
  - RLAST retires that entry.
- Simultaneous push and retire in the same cycle leaves the count unchanged.
- When a table is full and a push arrives, bit8 is set and the transfer is not tracked.
- Error bits:
  - bit0: AWVALID deasserted, or AWID/AWADDR/AWLEN changed, while AWVALID && !AWREADY in the previous cycle.
  - bit1: WVALID deasserted while WVALID && !WREADY in the previous cycle.
  - bit2: the AR-channel equivalent of bit0.
  - bit3: WLAST != (beat_cnt == len) on a W handshake.
  - bit4–bit6: as described above.
  - bit7: RLAST != (beat_cnt == len) on an R handshake.
  - bit8: overflow.
  - bit9: timeout (optional feature).
- Counters and arithmetic: beat_cnt is LEN_W+1 bits. All CNT_W counters saturate at all-ones. done counters increment on retire.

Optional Feature:
- Macro: AXI_MON_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT (default 1024) is added, with a 16-bit watchdog per direction.
  - The watchdog resets on any W/B handshake (write) or R handshake (read), and while its outstanding count is 0.
  - Reaching TIMEOUT sets bit9 once; the watchdog then holds until reset.
- When undefined: bit9 is tied 0 and no watchdog logic exists.

Test Plan:
- AW id=3 len=3, four W beats with WLAST on beat 4, B id=3 OKAY → wr_done_cnt=1, wr_outstanding=0, err_sticky=0.
- AR id=1 len=1 then AR id=2 len=0; R id=2 last, then R id=1 ×2 with last on the second → rd_done_cnt=2, no errors.
- AWVALID high with AWREADY low, AWADDR changes 0x100→0x104 → bit0 set, err_pulse one cycle, clr clears it.
- AW len=1, WLAST on the first beat → bit3; R with RID=5 and no AR → bit6.
- MAX_OUT+1 ARs with no R → bit8, rd_outstanding=MAX_OUT.
- AXI_MON_TIMEOUT_EN, TIMEOUT=16: AW accepted, no W for 16 cycles → bit9 set; RST mid-burst → all outputs 0.

Source files
------------

// File: rtl/axi_txn_monitor.sv
// Passive AXI3/AXI4 transaction monitor: per-ID outstanding tracking, protocol checks, sticky errors and counters.
// Optional watchdog timeout (err bit9) is enabled by defining AXI_MON_TIMEOUT_EN.
module axi_txn_monitor #(
   parameter int ID_SIZE = 4,
   parameter int LEN_W   = 4,
   parameter int MAX_OUT = 8,
   parameter int CNT_W   = 16
`ifdef AXI_MON_TIMEOUT_EN
   , parameter int TIMEOUT = 1024
`endif
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         clr,
   input  logic                         AWVALID,
   input  logic                         AWREADY,
   input  logic [ID_SIZE-1:0]           AWID,
   input  logic [LEN_W-1:0]             AWLEN,
   input  logic [31:0]                  AWADDR,
   input  logic                         WVALID,
   input  logic                         WREADY,
   input  logic                         WLAST,
   input  logic                         BVALID,
   input  logic                         BREADY,
   input  logic [ID_SIZE-1:0]           BID,
   input  logic [1:0]                   BRESP,
   input  logic                         ARVALID,
   input  logic                         ARREADY,
   input  logic [ID_SIZE-1:0]           ARID,
   input  logic [LEN_W-1:0]             ARLEN,
   input  logic [31:0]                  ARADDR,
   input  logic                         RVALID,
   input  logic                         RREADY,
   input  logic                         RLAST,
   input  logic [ID_SIZE-1:0]           RID,
   input  logic [1:0]                   RRESP,
   output logic [$clog2(MAX_OUT+1)-1:0] wr_outstanding,
   output logic [$clog2(MAX_OUT+1)-1:0] rd_outstanding,
   output logic [CNT_W-1:0]             wr_done_cnt,
   output logic [CNT_W-1:0]             rd_done_cnt,
   output logic [CNT_W-1:0]             resp_err_cnt,
   output logic [9:0]                   err_sticky,
   output logic                         err_pulse
);

   localparam int OW = $clog2(MAX_OUT+1);
   localparam int BW = LEN_W + 1;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID  && WREADY;
   assign b_hs  = BVALID  && BREADY;
   assign ar_hs = ARVALID && ARREADY;
   assign r_hs  = RVALID  && RREADY;

   // Shadows of the previous cycle's stalled request, for VALID/payload stability
   logic                aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
   logic [ID_SIZE-1:0]  aw_id_q, aw_id_d, ar_id_q, ar_id_d;
   logic [LEN_W-1:0]    aw_len_q, aw_len_d, ar_len_q, ar_len_d;
   logic [31:0]         aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;

   // Tables are kept compacted: index 0 is always the oldest live entry
   logic [ID_SIZE-1:0]  wt_id_q   [MAX_OUT], wt_id_d   [MAX_OUT];
   logic [LEN_W-1:0]    wt_len_q  [MAX_OUT], wt_len_d  [MAX_OUT];
   logic [BW-1:0]       wt_beat_q [MAX_OUT], wt_beat_d [MAX_OUT];
   logic                wt_wdone_q[MAX_OUT], wt_wdone_d[MAX_OUT];
   logic [OW-1:0]       wr_cnt_q, wr_cnt_d;

   logic [ID_SIZE-1:0]  rt_id_q   [MAX_OUT], rt_id_d   [MAX_OUT];
   logic [LEN_W-1:0]    rt_len_q  [MAX_OUT], rt_len_d  [MAX_OUT];
   logic [BW-1:0]       rt_beat_q [MAX_OUT], rt_beat_d [MAX_OUT];
   logic [OW-1:0]       rd_cnt_q, rd_cnt_d;

   logic [CNT_W-1:0]    wr_done_q, wr_done_d, rd_done_q, rd_done_d, resp_err_q, resp_err_d;
   logic [9:0]          err_sticky_q, err_sticky_d, err_new;
   logic                err_pulse_q, err_pulse_d;

   logic                err_w_last, err_w_orphan, err_b_orphan, err_wr_ovf, wr_retire;
   logic                err_r_last, err_r_orphan, err_rd_ovf, rd_retire;
   logic                to_evt;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(inc);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   always_comb begin
      aw_pend_d = AWVALID && !AWREADY;
      aw_id_d   = AWID;
      aw_len_d  = AWLEN;
      aw_addr_d = AWADDR;
      w_pend_d  = WVALID && !WREADY;
      ar_pend_d = ARVALID && !ARREADY;
      ar_id_d   = ARID;
      ar_len_d  = ARLEN;
      ar_addr_d = ARADDR;
   end

   // Write table: W beat on oldest open entry, B retire by ID, then AW push
   always_comb begin
      int   wr_n, w_idx, b_idx;
      logic w_hit, b_hit, bypass;
      wt_id_d      = wt_id_q;
      wt_len_d     = wt_len_q;
      wt_beat_d    = wt_beat_q;
      wt_wdone_d   = wt_wdone_q;
      wr_cnt_d     = wr_cnt_q;
      err_w_last   = 1'b0;
      err_w_orphan = 1'b0;
      err_b_orphan = 1'b0;
      err_wr_ovf   = 1'b0;
      wr_retire    = 1'b0;
      w_hit        = 1'b0;
      b_hit        = 1'b0;
      w_idx        = 0;
      b_idx        = 0;
      wr_n         = int'(wr_cnt_q);
      for (int i = 0; i < MAX_OUT; i++) begin
         if (!w_hit && i < wr_n && !wt_wdone_q[i]) begin
            w_hit = 1'b1;
            w_idx = i;
         end
         if (!b_hit && i < wr_n && wt_wdone_q[i] && wt_id_q[i] == BID) begin
            b_hit = 1'b1;
            b_idx = i;
         end
      end
      bypass = aw_hs && w_hs && !w_hit;
      if (w_hs) begin
         if (w_hit) begin
            for (int i = 0; i < MAX_OUT; i++) begin
               if (i == w_idx) begin
                  if (WLAST != (wt_beat_q[i] == {1'b0, wt_len_q[i]})) err_w_last = 1'b1;
                  wt_beat_d[i] = wt_beat_q[i] + BW'(1);
                  if (WLAST) wt_wdone_d[i] = 1'b1;
               end
            end
         end else if (!aw_hs) begin
            err_w_orphan = 1'b1;
         end
      end
      if (b_hs) begin
         if (b_hit) begin
            wr_retire = 1'b1;
            for (int i = 0; i < MAX_OUT - 1; i++) begin
               if (i >= b_idx) begin
                  wt_id_d[i]    = wt_id_d[i+1];
                  wt_len_d[i]   = wt_len_d[i+1];
                  wt_beat_d[i]  = wt_beat_d[i+1];
                  wt_wdone_d[i] = wt_wdone_d[i+1];
               end
            end
            wt_id_d[MAX_OUT-1]    = '0;
            wt_len_d[MAX_OUT-1]   = '0;
            wt_beat_d[MAX_OUT-1]  = '0;
            wt_wdone_d[MAX_OUT-1] = 1'b0;
            wr_n = wr_n - 1;
         end else begin
            err_b_orphan = 1'b1;
         end
      end
      if (aw_hs) begin
         if (wr_n < MAX_OUT) begin
            for (int i = 0; i < MAX_OUT; i++) begin
               if (i == wr_n) begin
                  wt_id_d[i]    = AWID;
                  wt_len_d[i]   = AWLEN;
                  wt_beat_d[i]  = BW'(bypass);
                  wt_wdone_d[i] = bypass && WLAST;
               end
            end
            if (bypass && (WLAST != (AWLEN == '0))) err_w_last = 1'b1;
            wr_n = wr_n + 1;
         end else begin
            err_wr_ovf = 1'b1;
         end
      end
      wr_cnt_d = OW'(wr_n);
   end

   // Read table: R beat on oldest entry with matching ID, RLAST retires, then AR push
   always_comb begin
      int   rd_n, r_idx;
      logic r_hit;
      rt_id_d      = rt_id_q;
      rt_len_d     = rt_len_q;
      rt_beat_d    = rt_beat_q;
      rd_cnt_d     = rd_cnt_q;
      err_r_last   = 1'b0;
      err_r_orphan = 1'b0;
      err_rd_ovf   = 1'b0;
      rd_retire    = 1'b0;
      r_hit        = 1'b0;
      r_idx        = 0;
      rd_n         = int'(rd_cnt_q);
      for (int i = 0; i < MAX_OUT; i++) begin
         if (!r_hit && i < rd_n && rt_id_q[i] == RID) begin
            r_hit = 1'b1;
            r_idx = i;
         end
      end
      if (r_hs) begin
         if (r_hit) begin
            for (int i = 0; i < MAX_OUT; i++) begin
               if (i == r_idx) begin
                  if (RLAST != (rt_beat_q[i] == {1'b0, rt_len_q[i]})) err_r_last = 1'b1;
                  rt_beat_d[i] = rt_beat_q[i] + BW'(1);
               end
            end
            if (RLAST) begin
               rd_retire = 1'b1;
               for (int i = 0; i < MAX_OUT - 1; i++) begin
                  if (i >= r_idx) begin
                     rt_id_d[i]   = rt_id_d[i+1];
                     rt_len_d[i]  = rt_len_d[i+1];
                     rt_beat_d[i] = rt_beat_d[i+1];
                  end
               end
               rt_id_d[MAX_OUT-1]   = '0;
               rt_len_d[MAX_OUT-1]  = '0;
               rt_beat_d[MAX_OUT-1] = '0;
               rd_n = rd_n - 1;
            end
         end else begin
            err_r_orphan = 1'b1;
         end
      end
      if (ar_hs) begin
         if (rd_n < MAX_OUT) begin
            for (int i = 0; i < MAX_OUT; i++) begin
               if (i == rd_n) begin
                  rt_id_d[i]   = ARID;
                  rt_len_d[i]  = ARLEN;
                  rt_beat_d[i] = '0;
               end
            end
            rd_n = rd_n + 1;
         end else begin
            err_rd_ovf = 1'b1;
         end
      end
      rd_cnt_d = OW'(rd_n);
   end

`ifdef AXI_MON_TIMEOUT_EN
   logic [15:0] wr_wd_q, wr_wd_d, rd_wd_q, rd_wd_d;
   logic        wr_trip_q, wr_trip_d, rd_trip_q, rd_trip_d;

   // Each watchdog fires once, then stays frozen until RST
   always_comb begin
      wr_wd_d   = wr_wd_q;
      rd_wd_d   = rd_wd_q;
      wr_trip_d = wr_trip_q;
      rd_trip_d = rd_trip_q;
      to_evt    = 1'b0;
      if (!wr_trip_q) begin
         if (wr_cnt_q == '0 || w_hs || b_hs) begin
            wr_wd_d = '0;
         end else begin
            wr_wd_d = wr_wd_q + 16'd1;
            if (wr_wd_d == 16'(TIMEOUT)) begin
               wr_trip_d = 1'b1;
               to_evt    = 1'b1;
            end
         end
      end
      if (!rd_trip_q) begin
         if (rd_cnt_q == '0 || r_hs) begin
            rd_wd_d = '0;
         end else begin
            rd_wd_d = rd_wd_q + 16'd1;
            if (rd_wd_d == 16'(TIMEOUT)) begin
               rd_trip_d = 1'b1;
               to_evt    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_wd_q   <= '0;
         rd_wd_q   <= '0;
         wr_trip_q <= 1'b0;
         rd_trip_q <= 1'b0;
      end else begin
         wr_wd_q   <= wr_wd_d;
         rd_wd_q   <= rd_wd_d;
         wr_trip_q <= wr_trip_d;
         rd_trip_q <= rd_trip_d;
      end
   end
`else
   assign to_evt = 1'b0;
`endif

   always_comb begin
      err_new    = '0;
      err_new[0] = aw_pend_q && (!AWVALID || AWID != aw_id_q || AWADDR != aw_addr_q || AWLEN != aw_len_q);
      err_new[1] = w_pend_q && !WVALID;
      err_new[2] = ar_pend_q && (!ARVALID || ARID != ar_id_q || ARADDR != ar_addr_q || ARLEN != ar_len_q);
      err_new[3] = err_w_last;
      err_new[4] = err_w_orphan;
      err_new[5] = err_b_orphan;
      err_new[6] = err_r_orphan;
      err_new[7] = err_r_last;
      err_new[8] = err_wr_ovf || err_rd_ovf;
      err_new[9] = to_evt;
   end

   // clr takes priority over any event in the same cycle
   always_comb begin
      err_sticky_d = err_sticky_q | err_new;
      err_pulse_d  = |(err_new & ~err_sticky_q);
      wr_done_d    = sat_add(wr_done_q, {1'b0, wr_retire});
      rd_done_d    = sat_add(rd_done_q, {1'b0, rd_retire});
      resp_err_d   = sat_add(resp_err_q, {1'b0, b_hs && BRESP != 2'b00} + {1'b0, r_hs && RRESP != 2'b00});
      if (clr) begin
         err_sticky_d = '0;
         err_pulse_d  = 1'b0;
         wr_done_d    = '0;
         rd_done_d    = '0;
         resp_err_d   = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         aw_pend_q    <= 1'b0;
         aw_id_q      <= '0;
         aw_len_q     <= '0;
         aw_addr_q    <= '0;
         w_pend_q     <= 1'b0;
         ar_pend_q    <= 1'b0;
         ar_id_q      <= '0;
         ar_len_q     <= '0;
         ar_addr_q    <= '0;
         wt_id_q      <= '{default: '0};
         wt_len_q     <= '{default: '0};
         wt_beat_q    <= '{default: '0};
         wt_wdone_q   <= '{default: 1'b0};
         wr_cnt_q     <= '0;
         rt_id_q      <= '{default: '0};
         rt_len_q     <= '{default: '0};
         rt_beat_q    <= '{default: '0};
         rd_cnt_q     <= '0;
         wr_done_q    <= '0;
         rd_done_q    <= '0;
         resp_err_q   <= '0;
         err_sticky_q <= '0;
         err_pulse_q  <= 1'b0;
      end else begin
         aw_pend_q    <= aw_pend_d;
         aw_id_q      <= aw_id_d;
         aw_len_q     <= aw_len_d;
         aw_addr_q    <= aw_addr_d;
         w_pend_q     <= w_pend_d;
         ar_pend_q    <= ar_pend_d;
         ar_id_q      <= ar_id_d;
         ar_len_q     <= ar_len_d;
         ar_addr_q    <= ar_addr_d;
         wt_id_q      <= wt_id_d;
         wt_len_q     <= wt_len_d;
         wt_beat_q    <= wt_beat_d;
         wt_wdone_q   <= wt_wdone_d;
         wr_cnt_q     <= wr_cnt_d;
         rt_id_q      <= rt_id_d;
         rt_len_q     <= rt_len_d;
         rt_beat_q    <= rt_beat_d;
         rd_cnt_q     <= rd_cnt_d;
         wr_done_q    <= wr_done_d;
         rd_done_q    <= rd_done_d;
         resp_err_q   <= resp_err_d;
         err_sticky_q <= err_sticky_d;
         err_pulse_q  <= err_pulse_d;
      end
   end

   assign wr_outstanding = wr_cnt_q;
   assign rd_outstanding = rd_cnt_q;
   assign wr_done_cnt    = wr_done_q;
   assign rd_done_cnt    = rd_done_q;
   assign resp_err_cnt   = resp_err_q;
   assign err_sticky     = err_sticky_q;
   assign err_pulse      = err_pulse_q;

endmodule

// File: tb/tb_axi_txn_monitor.sv
// Bench for axi_txn_monitor: queue-based reference model compared every cycle, plus directed literal checks.
// Define AXI_MON_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=16.
module tb_axi_txn_monitor;

   localparam int ID_SIZE = 4;
   localparam int LEN_W   = 4;
   localparam int MAX_OUT = 8;
   localparam int CNT_W   = 16;
   localparam int OW      = $clog2(MAX_OUT+1);
   localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef AXI_MON_TIMEOUT_EN
   localparam int TIMEOUT_T = 16;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic clr = 1'b0;
   logic AWVALID = 0, AWREADY = 0, WVALID = 0, WREADY = 0, WLAST = 0, BVALID = 0, BREADY = 0;
   logic ARVALID = 0, ARREADY = 0, RVALID = 0, RREADY = 0, RLAST = 0;
   logic [ID_SIZE-1:0] AWID = '0, ARID = '0, BID = '0, RID = '0;
   logic [LEN_W-1:0]   AWLEN = '0, ARLEN = '0;
   logic [31:0]        AWADDR = '0, ARADDR = '0;
   logic [1:0]         BRESP = '0, RRESP = '0;
   logic [OW-1:0]      wr_outstanding, rd_outstanding;
   logic [CNT_W-1:0]   wr_done_cnt, rd_done_cnt, resp_err_cnt;
   logic [9:0]         err_sticky;
   logic               err_pulse;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   axi_txn_monitor #(
      .ID_SIZE(ID_SIZE), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
`ifdef AXI_MON_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT_T)
`endif
   ) dut (
      .CLK(CLK), .RST(RST), .clr(clr),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
      .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RRESP(RRESP),
      .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
      .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt), .resp_err_cnt(resp_err_cnt),
      .err_sticky(err_sticky), .err_pulse(err_pulse)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int id; int len; int beats; bit wdone; } went_t;
   typedef struct { int id; int len; int beats; } rent_t;
   went_t wq[$];
   rent_t rq[$];
   int    m_wr_done = 0, m_rd_done = 0, m_resp_err = 0;
   bit [9:0] m_sticky = '0;
   bit    m_pulse = 1'b0;
   bit    p_aw_pend = 0, p_w_pend = 0, p_ar_pend = 0;
   logic [ID_SIZE-1:0] p_awid = '0, p_arid = '0;
   logic [LEN_W-1:0]   p_awlen = '0, p_arlen = '0;
   logic [31:0]        p_awaddr = '0, p_araddr = '0;
`ifdef AXI_MON_TIMEOUT_EN
   int wr_idle = 0, rd_idle = 0;
   bit wr_trip = 0, rd_trip = 0;
`endif

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         wq.delete();
         rq.delete();
         m_wr_done = 0; m_rd_done = 0; m_resp_err = 0;
         m_sticky = '0; m_pulse = 1'b0;
         p_aw_pend = 0; p_w_pend = 0; p_ar_pend = 0;
         p_awid = '0; p_arid = '0; p_awlen = '0; p_arlen = '0; p_awaddr = '0; p_araddr = '0;
`ifdef AXI_MON_TIMEOUT_EN
         wr_idle = 0; rd_idle = 0; wr_trip = 0; rd_trip = 0;
`endif
      end else begin
         bit [9:0] ev;
         bit awh, wh, bh, arh, rh;
         int open_i, closed_i, r_i, wsz, rsz, resp_inc;
         went_t we;
         rent_t re;
         ev = '0;
         awh = AWVALID && AWREADY; wh = WVALID && WREADY; bh = BVALID && BREADY;
         arh = ARVALID && ARREADY; rh = RVALID && RREADY;
         wsz = wq.size();
         rsz = rq.size();
         if (p_aw_pend && (!AWVALID || AWID != p_awid || AWADDR != p_awaddr || AWLEN != p_awlen)) ev[0] = 1;
         if (p_w_pend && !WVALID) ev[1] = 1;
         if (p_ar_pend && (!ARVALID || ARID != p_arid || ARADDR != p_araddr || ARLEN != p_arlen)) ev[2] = 1;

         open_i = -1; closed_i = -1; r_i = -1;
         for (int i = 0; i < wsz; i++) begin
            if (open_i < 0 && !wq[i].wdone) open_i = i;
            if (closed_i < 0 && wq[i].wdone && wq[i].id == int'(BID)) closed_i = i;
         end
         for (int i = 0; i < rsz; i++)
            if (r_i < 0 && rq[i].id == int'(RID)) r_i = i;

         if (wh) begin
            if (open_i >= 0) begin
               we = wq[open_i];
               if (WLAST != (we.beats == we.len)) ev[3] = 1;
               we.beats = we.beats + 1;
               if (WLAST) we.wdone = 1;
               wq[open_i] = we;
            end else if (!awh) ev[4] = 1;
         end
         if (bh) begin
            if (closed_i >= 0) begin wq.delete(closed_i); m_wr_done++; end
            else ev[5] = 1;
         end
         if (awh) begin
            if (wq.size() < MAX_OUT) begin
               we.id = int'(AWID); we.len = int'(AWLEN); we.beats = 0; we.wdone = 0;
               if (wh && open_i < 0) begin
                  if (WLAST != (we.len == 0)) ev[3] = 1;
                  we.beats = 1; we.wdone = WLAST;
               end
               wq.push_back(we);
            end else ev[8] = 1;
         end

         if (rh) begin
            if (r_i >= 0) begin
               re = rq[r_i];
               if (RLAST != (re.beats == re.len)) ev[7] = 1;
               if (RLAST) begin rq.delete(r_i); m_rd_done++; end
               else begin re.beats = re.beats + 1; rq[r_i] = re; end
            end else ev[6] = 1;
         end
         if (arh) begin
            if (rq.size() < MAX_OUT) begin
               re.id = int'(ARID); re.len = int'(ARLEN); re.beats = 0;
               rq.push_back(re);
            end else ev[8] = 1;
         end

`ifdef AXI_MON_TIMEOUT_EN
         if (!wr_trip) begin
            if (wsz == 0 || wh || bh) wr_idle = 0;
            else begin wr_idle++; if (wr_idle == TIMEOUT_T) begin wr_trip = 1; ev[9] = 1; end end
         end
         if (!rd_trip) begin
            if (rsz == 0 || rh) rd_idle = 0;
            else begin rd_idle++; if (rd_idle == TIMEOUT_T) begin rd_trip = 1; ev[9] = 1; end end
         end
`endif
         resp_inc = ((bh && BRESP != 2'b00) ? 1 : 0) + ((rh && RRESP != 2'b00) ? 1 : 0);
         if (clr) begin
            m_sticky = '0; m_pulse = 0; m_wr_done = 0; m_rd_done = 0; m_resp_err = 0;
         end else begin
            m_pulse    = |(ev & ~m_sticky);
            m_sticky   = m_sticky | ev;
            m_resp_err = (m_resp_err + resp_inc > CMAX) ? CMAX : m_resp_err + resp_inc;
            if (m_wr_done > CMAX) m_wr_done = CMAX;
            if (m_rd_done > CMAX) m_rd_done = CMAX;
         end
         p_aw_pend = AWVALID && !AWREADY; p_awid = AWID; p_awaddr = AWADDR; p_awlen = AWLEN;
         p_w_pend  = WVALID && !WREADY;
         p_ar_pend = ARVALID && !ARREADY; p_arid = ARID; p_araddr = ARADDR; p_arlen = ARLEN;
      end
   end

   // ---------------- every-cycle compare ----------------
   always @(negedge CLK) begin
      chk("wr_outstanding", 32'(wr_outstanding), wq.size());
      chk("rd_outstanding", 32'(rd_outstanding), rq.size());
      chk("wr_done_cnt", 32'(wr_done_cnt), m_wr_done);
      chk("rd_done_cnt", 32'(rd_done_cnt), m_rd_done);
      chk("resp_err_cnt", 32'(resp_err_cnt), m_resp_err);
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
   end

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_aw(input int id, input int len);
      AWVALID = 1; AWREADY = 1; AWID = ID_SIZE'(id); AWLEN = LEN_W'(len); AWADDR = 32'h1000;
      step();
      AWVALID = 0; AWREADY = 0;
   endtask

   task automatic do_w(input logic last);
      WVALID = 1; WREADY = 1; WLAST = last;
      step();
      WVALID = 0; WREADY = 0; WLAST = 0;
   endtask

   task automatic do_b(input int id, input logic [1:0] resp);
      BVALID = 1; BREADY = 1; BID = ID_SIZE'(id); BRESP = resp;
      step();
      BVALID = 0; BREADY = 0; BRESP = 2'b00;
   endtask

   task automatic do_ar(input int id, input int len);
      ARVALID = 1; ARREADY = 1; ARID = ID_SIZE'(id); ARLEN = LEN_W'(len); ARADDR = 32'h2000;
      step();
      ARVALID = 0; ARREADY = 0;
   endtask

   task automatic do_r(input int id, input logic last, input logic [1:0] resp);
      RVALID = 1; RREADY = 1; RID = ID_SIZE'(id); RLAST = last; RRESP = resp;
      step();
      RVALID = 0; RREADY = 0; RLAST = 0; RRESP = 2'b00;
   endtask

   task automatic do_clr();
      clr = 1;
      step();
      clr = 0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      #1 RST = 1;
      idle(3);
      chk("reset_wr_out", 32'(wr_outstanding), 0);
      chk("reset_sticky", 32'(err_sticky), 0);
      RST = 0;
      idle(2);

      // write id=3 len=3, four beats, OKAY response
      do_aw(3, 3);
      do_w(0); do_w(0); do_w(0); do_w(1);
      do_b(3, 2'b00);
      chk("t1_wr_done", 32'(wr_done_cnt), 1);
      chk("t1_wr_out", 32'(wr_outstanding), 0);
      chk("t1_sticky", 32'(err_sticky), 0);

      // two reads completing out of order by ID
      do_ar(1, 1);
      do_ar(2, 0);
      chk("t2_rd_out", 32'(rd_outstanding), 2);
      do_r(2, 1, 2'b00);
      do_r(1, 0, 2'b00);
      do_r(1, 1, 2'b00);
      chk("t2_rd_done", 32'(rd_done_cnt), 2);
      chk("t2_sticky", 32'(err_sticky), 0);

      // AWADDR changes while stalled
      AWVALID = 1; AWREADY = 0; AWID = '0; AWLEN = '0; AWADDR = 32'h100;
      step();
      AWADDR = 32'h104;
      step();
      chk("t3_bit0", 32'(err_sticky), 32'h001);
      chk("t3_pulse_hi", 32'(err_pulse), 1);
      AWREADY = 1;
      step();
      AWVALID = 0; AWREADY = 0;
      chk("t3_pulse_lo", 32'(err_pulse), 0);
      chk("t3_wr_out", 32'(wr_outstanding), 1);
      do_w(1);
      do_b(0, 2'b00);
      chk("t3_wr_done", 32'(wr_done_cnt), 2);
      do_clr();
      chk("t3_clr_sticky", 32'(err_sticky), 0);
      chk("t3_clr_wr_done", 32'(wr_done_cnt), 0);
      chk("t3_clr_rd_done", 32'(rd_done_cnt), 0);

      // WLAST too early, orphan R, orphan W, orphan B
      do_aw(5, 1);
      do_w(1);
      chk("t4_bit3", 32'(err_sticky), 32'h008);
      do_b(5, 2'b00);
      do_r(5, 1, 2'b00);
      chk("t4_bit6", 32'(err_sticky), 32'h048);
      do_w(1);
      do_b(9, 2'b00);
      chk("t4_bit4_5", 32'(err_sticky), 32'h078);
      do_clr();

      // AW and W in the same cycle with nothing open
      AWVALID = 1; AWREADY = 1; AWID = 4'd2; AWLEN = '0; AWADDR = 32'h3000;
      WVALID = 1; WREADY = 1; WLAST = 1;
      step();
      AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0;
      chk("t5_bypass_sticky", 32'(err_sticky), 0);
      chk("t5_bypass_out", 32'(wr_outstanding), 1);
      do_b(2, 2'b10);
      chk("t5_wr_done", 32'(wr_done_cnt), 1);
      chk("t5_resp_err", 32'(resp_err_cnt), 1);

      // read table overflow then drain
      for (int i = 0; i < MAX_OUT + 1; i++) do_ar(7, 0);
      chk("t6_rd_out_full", 32'(rd_outstanding), MAX_OUT);
      chk("t6_bit8", 32'(err_sticky), 32'h100);
      for (int i = 0; i < MAX_OUT; i++) do_r(7, 1, (i == 0) ? 2'b11 : 2'b00);
      chk("t6_rd_out_empty", 32'(rd_outstanding), 0);
      chk("t6_rd_done", 32'(rd_done_cnt), MAX_OUT);
      chk("t6_resp_err", 32'(resp_err_cnt), 2);
      do_clr();

`ifdef AXI_MON_TIMEOUT_EN
      do_aw(1, 0);
      idle(TIMEOUT_T - 1);
      chk("t7_no_timeout_yet", 32'(err_sticky), 0);
      idle(1);
      chk("t7_bit9", 32'(err_sticky), 32'h200);
`endif

      // reset in the middle of a burst
      do_aw(3, 3);
      do_w(0);
      do_w(0);
      RST = 1;
      #2;
      chk("t8_rst_wr_out", 32'(wr_outstanding), 0);
      chk("t8_rst_rd_out", 32'(rd_outstanding), 0);
      chk("t8_rst_wr_done", 32'(wr_done_cnt), 0);
      chk("t8_rst_resp_err", 32'(resp_err_cnt), 0);
      chk("t8_rst_sticky", 32'(err_sticky), 0);
      chk("t8_rst_pulse", 32'(err_pulse), 0);
      step();
      RST = 0;
      idle(1);
      do_b(3, 2'b00);
      chk("t8_post_rst_bit5", 32'(err_sticky), 32'h020);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
